sim_extmem_pipe: RTL and testbench

SIM_EXTMEM_PIPE -- requirements
Module: sim_extmem_pipe

---
 rtl/sim_extmem_pipe_if.sv | 36 +++
 rtl/sim_extmem_pipe.sv | 211 +++++++++++++++++++++
 tb/tb_sim_extmem_pipe.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/sim_extmem_pipe_if.sv
// -----------------------------------------------------------------------------
// sim_extmem_pipe_if
// Bundles the request/grant handshake, the command bus and the read-return bus
// of sim_extmem_pipe.
//   master : the requester (drives req, ce, w, a, tag, d, be; sees ready,
//            valid, q, qtag, err_cnt)
//   slave  : the memory model (the reverse directions)
// -----------------------------------------------------------------------------
interface sim_extmem_pipe_if #(
    parameter int DATA_WIDTH    = 128,
    parameter int TAG_WIDTH     = 2,
    parameter int ADDRESS_WIDTH = 32
);
    logic                       req;
    logic                       ready;
    logic                       ce;
    logic                       w;
    logic [ADDRESS_WIDTH-1:0]   a;
    logic [TAG_WIDTH-1:0]       tag;
    logic [DATA_WIDTH-1:0]      d;
    logic [DATA_WIDTH/8-1:0]    be;
    logic                       valid;
    logic [DATA_WIDTH-1:0]      q;
    logic [TAG_WIDTH-1:0]       qtag;
    logic [15:0]                err_cnt;

    modport master (
        output req, ce, w, a, tag, d, be,
        input  ready, valid, q, qtag, err_cnt
    );

    modport slave (
        input  req, ce, w, a, tag, d, be,
        output ready, valid, q, qtag, err_cnt
    );
endinterface

// File: rtl/sim_extmem_pipe.sv
// -----------------------------------------------------------------------------
// sim_extmem_pipe
// Simulated external memory with a request/grant handshake, byte-enabled
// writes and a fixed-latency, fully pipelined read path.
//
// Ports
//   clk    : clock, rising edge
//   rst_n  : synchronous active-low reset
//   bus    : sim_extmem_pipe_if.slave
//            req/ready      access request and registered grant
//            ce/w/a/tag     command strobe, write select, word address, tag
//            d/be           write data and byte enables (be also masks reads)
//            valid/q/qtag   read return, READ_LATENCY cycles after acceptance
//            err_cnt        saturating count of dropped / out-of-range commands
//
// Build option
//   SIM_EXTMEM_NOISE_EN : when defined, a free-running counter withholds the
//                         grant for NOISE_LEN cycles out of every NOISE_PERIOD.
//                         When undefined, ready simply follows req one cycle
//                         later and the counter does not exist.
//
// Memory contents are not reset; only control state and the read pipeline are.
// -----------------------------------------------------------------------------
module sim_extmem_pipe #(
    parameter int DATA_WIDTH    = 128,
    parameter int TAG_WIDTH     = 2,
    parameter int ADDRESS_WIDTH = 32,
    parameter int DEPTH         = 64,
    parameter int READ_LATENCY  = 4,
    parameter int NOISE_PERIOD  = 33,
    parameter int NOISE_LEN     = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    sim_extmem_pipe_if.slave bus
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int BE_W  = DATA_WIDTH / 8;

    // ------------------------------------------------------------------
    // Stall pattern
    // ------------------------------------------------------------------
    logic stall;

`ifdef SIM_EXTMEM_NOISE_EN
    localparam int CNT_W = $clog2(NOISE_PERIOD + 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(NOISE_PERIOD - 1)) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign stall = (cnt_q >= CNT_W'(NOISE_PERIOD - NOISE_LEN));
`else
    assign stall = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Command decode
    // ------------------------------------------------------------------
    logic             ready_q;
    logic             ready_d;
    logic [15:0]      err_q;
    logic [15:0]      err_d;
    logic             accept;
    logic             wr_en;
    logic             rd_en;
    logic             addr_oob;
    logic [IDX_W-1:0] idx;

    assign idx      = bus.a[IDX_W-1:0];
    assign addr_oob = |(bus.a >> IDX_W);
    // Gated with rst_n so a command presented on a reset edge never touches
    // the memory array, which itself is not reset.
    assign accept   = bus.ce && ready_q && rst_n;
    assign wr_en    = accept && bus.w;
    assign rd_en    = accept && !bus.w;

    always_comb begin
        ready_d = bus.req && !stall;
        err_d   = err_q;
        // A dropped command and an accepted out-of-range one are mutually
        // exclusive, so at most one increment per cycle.
        if ((bus.ce && !ready_q) || (accept && addr_oob)) begin
            if (err_q != 16'hFFFF) begin
                err_d = err_q + 16'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Memory array: byte-enabled write, registered read
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] mem_rd_q;

    always_ff @(posedge clk) begin
        for (int i = 0; i < BE_W; i++) begin
            if (wr_en && bus.be[i]) begin
                mem[idx][i*8 +: 8] <= bus.d[i*8 +: 8];
            end
        end
    end

    // Only loaded for accepted reads; stale contents are masked off by the
    // stage-0 valid bit below, so this register needs no reset.
    always_ff @(posedge clk) begin
        if (rd_en) begin
            mem_rd_q <= mem[idx];
        end
    end

    // ------------------------------------------------------------------
    // Read pipeline
    // Stage 0 travels alongside the memory read register; stages
    // 1..READ_LATENCY follow, and the last stage drives the outputs, so data
    // leaves exactly READ_LATENCY edges after the accepting edge.
    // ------------------------------------------------------------------
    logic                 s0_valid_q;
    logic                 s0_valid_d;
    logic [TAG_WIDTH-1:0] s0_tag_q;
    logic [TAG_WIDTH-1:0] s0_tag_d;
    logic [BE_W-1:0]      s0_be_q;
    logic [BE_W-1:0]      s0_be_d;

    always_comb begin
        s0_valid_d = rd_en;
        s0_tag_d   = rd_en ? bus.tag : '0;
        s0_be_d    = rd_en ? bus.be  : '0;
    end

    // Byte enables widened to a bit mask for the read data.
    logic [DATA_WIDTH-1:0] be_mask;

    for (genvar gi = 0; gi < BE_W; gi++) begin : g_be_mask
        assign be_mask[gi*8 +: 8] = {8{s0_be_q[gi]}};
    end

    logic                  pv_q [1:READ_LATENCY];
    logic                  pv_d [1:READ_LATENCY];
    logic [DATA_WIDTH-1:0] pd_q [1:READ_LATENCY];
    logic [DATA_WIDTH-1:0] pd_d [1:READ_LATENCY];
    logic [TAG_WIDTH-1:0]  pt_q [1:READ_LATENCY];
    logic [TAG_WIDTH-1:0]  pt_d [1:READ_LATENCY];

    // Data and tag are forced to zero in empty slots so the outputs are zero
    // whenever valid is low without any extra output muxing.
    always_comb begin
        pv_d[1] = s0_valid_q;
        pd_d[1] = s0_valid_q ? (mem_rd_q & be_mask) : '0;
        pt_d[1] = s0_valid_q ? s0_tag_q : '0;
        for (int k = 2; k <= READ_LATENCY; k++) begin
            pv_d[k] = pv_q[k-1];
            pd_d[k] = pd_q[k-1];
            pt_d[k] = pt_q[k-1];
        end
    end

    // ------------------------------------------------------------------
    // Control and pipeline registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ready_q    <= 1'b0;
            err_q      <= '0;
            s0_valid_q <= 1'b0;
            s0_tag_q   <= '0;
            s0_be_q    <= '0;
            for (int k = 1; k <= READ_LATENCY; k++) begin
                pv_q[k] <= 1'b0;
                pd_q[k] <= '0;
                pt_q[k] <= '0;
            end
        end else begin
            ready_q    <= ready_d;
            err_q      <= err_d;
            s0_valid_q <= s0_valid_d;
            s0_tag_q   <= s0_tag_d;
            s0_be_q    <= s0_be_d;
            for (int k = 1; k <= READ_LATENCY; k++) begin
                pv_q[k] <= pv_d[k];
                pd_q[k] <= pd_d[k];
                pt_q[k] <= pt_d[k];
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.ready   = ready_q;
    assign bus.err_cnt = err_q;
    assign bus.valid   = pv_q[READ_LATENCY];
    assign bus.q       = pd_q[READ_LATENCY];
    assign bus.qtag    = pt_q[READ_LATENCY];

endmodule

// File: tb/tb_sim_extmem_pipe.sv
// -----------------------------------------------------------------------------
// tb_sim_extmem_pipe
// Drives sim_extmem_pipe with directed and random commands and compares every
// output on every cycle against a transaction-level model: a word array for
// memory, a queue of expected read returns keyed by their due edge, a
// saturating error count and the grant rule derived from cycles since reset.
// -----------------------------------------------------------------------------
module tb_sim_extmem_pipe;

    localparam int DW    = 128;
    localparam int TW    = 2;
    localparam int AW    = 32;
    localparam int DEPTH = 64;
    localparam int LAT   = 4;
    localparam int NP    = 33;
    localparam int NL    = 2;
    localparam int BW    = DW / 8;

`ifdef SIM_EXTMEM_NOISE_EN
    localparam bit NOISE = 1'b1;
`else
    localparam bit NOISE = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    sim_extmem_pipe_if #(.DATA_WIDTH(DW), .TAG_WIDTH(TW), .ADDRESS_WIDTH(AW)) bus ();

    sim_extmem_pipe #(
        .DATA_WIDTH    (DW),
        .TAG_WIDTH     (TW),
        .ADDRESS_WIDTH (AW),
        .DEPTH         (DEPTH),
        .READ_LATENCY  (LAT),
        .NOISE_PERIOD  (NP),
        .NOISE_LEN     (NL)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    typedef struct packed {
        int            due;
        logic [DW-1:0] data;
        logic [TW-1:0] tag;
    } exp_t;

    logic [DW-1:0] mem_m [DEPTH];
    exp_t          exp_q [$];
    bit            ready_m;
    int            err_m;
    int            since_rst;
    int            edge_n;
    int            n_tests;
    int            n_fail;

    task automatic chk(input string name, input logic [DW-1:0] got, input logic [DW-1:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s at edge %0d: got %0h, want %0h", name, edge_n, got, want);
        end
    endtask

    function automatic logic [DW-1:0] byte_mask(input logic [BW-1:0] be);
        logic [DW-1:0] m;
        for (int i = 0; i < BW; i++) m[i*8 +: 8] = be[i] ? 8'hFF : 8'h00;
        return m;
    endfunction

    // Applies the effect of one clock edge to the model using the inputs as
    // they stood at that edge.
    task automatic model_edge();
        edge_n++;
        if (!rst_n) begin
            ready_m   = 1'b0;
            err_m     = 0;
            since_rst = 0;
            exp_q.delete();
        end else begin
            int  idx;
            bit  bump;
            exp_t e;
            bump = 1'b0;
            if (bus.ce && !ready_m) bump = 1'b1;
            if (bus.ce && ready_m) begin
                idx = int'(bus.a % DEPTH);
                if (bus.a >= DEPTH) bump = 1'b1;
                if (bus.w) begin
                    mem_m[idx] = (mem_m[idx] & ~byte_mask(bus.be)) | (bus.d & byte_mask(bus.be));
                end else begin
                    e.due  = edge_n + LAT;
                    e.data = mem_m[idx] & byte_mask(bus.be);
                    e.tag  = bus.tag;
                    exp_q.push_back(e);
                end
            end
            if (bump && err_m < 16'hFFFF) err_m++;
            ready_m = bus.req && !(NOISE && ((since_rst % NP) >= NP - NL));
            since_rst++;
        end
    endtask

    task automatic check_outputs();
        exp_t e;
        bit   v;
        v = 1'b0;
        e = '0;
        if (exp_q.size() > 0 && exp_q[0].due == edge_n) begin
            e = exp_q.pop_front();
            v = 1'b1;
        end
        chk("valid",   DW'(bus.valid),   DW'(v));
        chk("q",       bus.q,            e.data);
        chk("qtag",    DW'(bus.qtag),    DW'(e.tag));
        chk("ready",   DW'(bus.ready),   DW'(ready_m));
        chk("err_cnt", DW'(bus.err_cnt), DW'(err_m));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
    endtask

    task automatic idle(input int n);
        bus.ce = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    // Waits (bounded) for a grant, then presents one command for one edge.
    task automatic cmd(input bit w, input int a, input int tag,
                       input logic [DW-1:0] d, input logic [BW-1:0] be);
        int n;
        n = 0;
        bus.req = 1'b1;
        bus.ce  = 1'b0;
        while (!ready_m && n < 100) begin
            step();
            n++;
        end
        if (!ready_m) begin
            n_tests++;
            n_fail++;
            $display("FAIL grant_wait: no grant after %0d cycles, want grant", n);
        end
        bus.ce  = 1'b1;
        bus.w   = w;
        bus.a   = AW'(a);
        bus.tag = TW'(tag);
        bus.d   = d;
        bus.be  = be;
        $display("[TB] edge %0d %s a=%0d tag=%0d be=%h d=%h", edge_n + 1, w ? "WR" : "RD", a, tag, be, d);
        step();
        bus.ce = 1'b0;
    endtask

    function automatic logic [DW-1:0] rand_word();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        int lows;
        n_tests   = 0;
        n_fail    = 0;
        edge_n    = 0;
        since_rst = 0;
        ready_m   = 1'b0;
        err_m     = 0;
        bus.req   = 1'b0;
        bus.ce    = 1'b0;
        bus.w     = 1'b0;
        bus.a     = '0;
        bus.tag   = '0;
        bus.d     = '0;
        bus.be    = '0;

        // Reset state, then release with req held high from the start.
        rst_n = 1'b0;
        idle(3);
        bus.req = 1'b1;
        #1;
        rst_n = 1'b1;

        // Grant pattern over two full noise periods.
        lows = 0;
        for (int i = 0; i < 2 * NP; i++) begin
            step();
            if (!bus.ready) lows++;
        end
        chk("ready_low_count", DW'(lows), DW'(NOISE ? 2 * NL : 0));

        // Fill every word with known contents.
        for (int i = 0; i < DEPTH; i++) cmd(1'b1, i, 0, rand_word(), '1);
        idle(LAT + 1);

        // Full-word write then read back with tag 2.
        cmd(1'b1, 5, 0, 128'h0123456789ABCDEF0123456789ABCDEF, '1);
        cmd(1'b0, 5, 2, '0, '1);
        idle(LAT + 1);

        // Partial write, then full and half-masked reads.
        cmd(1'b1, 7, 0, rand_word(), 16'h000F);
        cmd(1'b0, 7, 1, '0, 16'hFFFF);
        cmd(1'b0, 7, 3, '0, 16'h00FF);
        idle(LAT + 1);

        // Back-to-back reads with cycling tags.
        for (int i = 0; i < 16; i++) cmd(1'b0, i, i % 4, '0, '1);
        idle(LAT + 1);

        // Out-of-range addresses wrap and count as errors.
        cmd(1'b0, DEPTH, 1, '0, '1);
        cmd(1'b1, DEPTH + 3, 0, rand_word(), '1);
        cmd(1'b0, 3, 2, '0, '1);
        idle(LAT + 1);

        // A strobe while the grant is withheld is dropped and counted.
        bus.req = 1'b1;
        for (int i = 0; i < 2 * NP && ready_m; i++) step();
        if (!ready_m) begin
            bus.ce = 1'b1;
            bus.w  = 1'b0;
            bus.a  = AW'(9);
            $display("[TB] edge %0d RD a=9 while not granted", edge_n + 1);
            step();
            bus.ce = 1'b0;
        end
        idle(LAT + 1);

        // Reset in the middle of a read burst.
        cmd(1'b0, 10, 0, '0, '1);
        cmd(1'b0, 11, 1, '0, '1);
        cmd(1'b0, 12, 2, '0, '1);
        idle(1);
        rst_n = 1'b0;
        idle(2);
        #1;
        rst_n = 1'b1;
        idle(LAT + 3);
        cmd(1'b0, 10, 0, '0, '1);
        cmd(1'b0, 5, 1, '0, '1);
        idle(LAT + 1);

        // Random traffic.
        for (int i = 0; i < 300; i++) begin
            bus.req = ($urandom_range(9) != 0);
            bus.ce  = $urandom_range(1);
            bus.w   = $urandom_range(1);
            bus.a   = ($urandom_range(9) == 0) ? AW'($urandom_range(2 * DEPTH - 1))
                                               : AW'($urandom_range(DEPTH - 1));
            bus.tag = TW'($urandom);
            bus.d   = rand_word();
            bus.be  = BW'($urandom);
            if (bus.ce)
                $display("[TB] edge %0d %s a=%0d tag=%0d be=%h", edge_n + 1,
                         bus.w ? "WR" : "RD", bus.a, bus.tag, bus.be);
            step();
        end
        bus.req = 1'b1;
        idle(LAT + 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
